// File: rtl/avr_irq_sequencer_if.sv
// Signal bundle between the interrupt sequencer, the peripheral flags and the CU.
// The master side drives requests and CU status; the slave side is the sequencer.
interface avr_irq_sequencer_if #(
   parameter int N_IRQ = 25,
   parameter int PC_W  = 14
);
   logic [N_IRQ-1:0] irq_req;
   logic             i_flag;
   logic             inst_done;
   logic             reti_done;
   logic [PC_W-1:0]  pc_ret;

   logic             stall_cu;
   logic [N_IRQ-1:0] irq_ack;
   logic             clr_i;
   logic             stack_wr;
   logic [7:0]       stack_data;
   logic             pc_load;
   logic [PC_W-1:0]  pc_vec;
   logic             irq_active;

   modport master (
      output irq_req, i_flag, inst_done, reti_done, pc_ret,
      input  stall_cu, irq_ack, clr_i, stack_wr, stack_data, pc_load, pc_vec, irq_active
   );

   modport slave (
      input  irq_req, i_flag, inst_done, reti_done, pc_ret,
      output stall_cu, irq_ack, clr_i, stack_wr, stack_data, pc_load, pc_vec, irq_active
   );
endinterface

// File: rtl/avr_irq_sequencer.sv
// AVR interrupt entry sequencer: at an instruction boundary takes the highest-priority
// request, stalls the CU, pushes the return PC low/high byte and jumps to the vector.
module avr_irq_sequencer #(
   parameter int N_IRQ    = 25,
   parameter int PC_W     = 14,
   parameter int VEC_BASE = 0
) (
   input logic                CLK,
   input logic                RST,
   avr_irq_sequencer_if.slave bus
);
   localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [2:0] {IDLE, SEL, PUSH_L, PUSH_H, JUMP} state_t;

   state_t           state, state_nxt;
   logic             hold_one, hold_nxt;
   logic [IDX_W-1:0] idx_lat, idx_nxt, winner;
   logic [PC_W-1:0]  pc_lat, pc_nxt;
   logic             take;

   logic             stall_nxt, clr_i_nxt, stack_wr_nxt, pc_load_nxt;
   logic [N_IRQ-1:0] ack_nxt;
   logic [7:0]       data_nxt;
   logic [PC_W-1:0]  vec_nxt;

   logic             stall_r, clr_i_r, stack_wr_r, pc_load_r;
   logic [N_IRQ-1:0] ack_r;
   logic [7:0]       data_r;
   logic [PC_W-1:0]  vec_r;

   function automatic logic [PC_W-1:0] vec_addr(input logic [IDX_W-1:0] i);
      logic [31:0] a;
      a = VEC_BASE + 2 * (32'(i) + 32'd1);
      return a[PC_W-1:0];
   endfunction

   function automatic logic [7:0] pc_hi(input logic [PC_W-1:0] p);
      logic [15:0] w;
      w = 16'(p);
      return w[15:8];
   endfunction

   // Lowest set index wins; scanning downward leaves the smallest index last.
   always_comb begin
      winner = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (bus.irq_req[i]) winner = IDX_W'(i);
      end
   end

   // A boundary coinciding with reti_done is consumed by the one-instruction hold.
   assign take = (state == IDLE) && bus.inst_done && bus.i_flag && (|bus.irq_req)
                 && !hold_one && !bus.reti_done;

   always_comb begin
      hold_nxt = hold_one;
      if (bus.reti_done)
         hold_nxt = 1'b1;
      else if (state == IDLE && bus.inst_done)
         hold_nxt = 1'b0;
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx_lat;
      pc_nxt       = pc_lat;
      stall_nxt    = 1'b0;
      clr_i_nxt    = 1'b0;
      stack_wr_nxt = 1'b0;
      pc_load_nxt  = 1'b0;
      ack_nxt      = '0;
      data_nxt     = '0;
      vec_nxt      = '0;

      case (state)
         IDLE: begin
            if (take) begin
               state_nxt = SEL;
               idx_nxt   = winner;
               pc_nxt    = bus.pc_ret;
            end
         end
         SEL:     state_nxt = PUSH_L;
         PUSH_L:  state_nxt = PUSH_H;
         PUSH_H:  state_nxt = JUMP;
         JUMP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      case (state_nxt)
         SEL: begin
            stall_nxt        = 1'b1;
            clr_i_nxt        = 1'b1;
            ack_nxt[idx_nxt] = 1'b1;
         end
         PUSH_L: begin
            stall_nxt    = 1'b1;
            stack_wr_nxt = 1'b1;
            data_nxt     = pc_nxt[7:0];
         end
         PUSH_H: begin
            stall_nxt    = 1'b1;
            stack_wr_nxt = 1'b1;
            data_nxt     = pc_hi(pc_nxt);
         end
         JUMP: begin
            stall_nxt   = 1'b1;
            pc_load_nxt = 1'b1;
            vec_nxt     = vec_addr(idx_nxt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         hold_one <= 1'b0;
         idx_lat  <= '0;
         pc_lat   <= '0;
      end else begin
         state    <= state_nxt;
         hold_one <= hold_nxt;
         idx_lat  <= idx_nxt;
         pc_lat   <= pc_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_r    <= 1'b0;
         clr_i_r    <= 1'b0;
         stack_wr_r <= 1'b0;
         pc_load_r  <= 1'b0;
         ack_r      <= '0;
         data_r     <= '0;
         vec_r      <= '0;
      end else begin
         stall_r    <= stall_nxt;
         clr_i_r    <= clr_i_nxt;
         stack_wr_r <= stack_wr_nxt;
         pc_load_r  <= pc_load_nxt;
         ack_r      <= ack_nxt;
         data_r     <= data_nxt;
         vec_r      <= vec_nxt;
      end
   end

   assign bus.stall_cu   = stall_r;
   assign bus.irq_active = stall_r;
   assign bus.clr_i      = clr_i_r;
   assign bus.stack_wr   = stack_wr_r;
   assign bus.pc_load    = pc_load_r;
   assign bus.irq_ack    = ack_r;
   assign bus.stack_data = data_r;
   assign bus.pc_vec     = vec_r;
endmodule

// File: doc/avr_irq_sequencer.md
Name: avr_irq_sequencer

Overview:
- Interrupt entry sequencer for the ATmega328p core.
- Sits between the peripheral interrupt flags and the CU.
- At an instruction boundary it picks the highest-priority pending source, stalls the CU, pushes the return PC (two bytes), and loads the vector address.
- Enforces the AVR rule that one main-program instruction executes after RETI before the next interrupt is taken.

Parameters:
- N_IRQ, 25, number of interrupt sources; index 0 has the highest priority.
- PC_W, 14, program counter width in words.
- VEC_BASE, 0, word address of the vector table. Reset occupies VEC_BASE; source k uses VEC_BASE + 2*(k+1).

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- irq_req  in  N_IRQ  level request flags, held by peripherals until acked.
- i_flag  in  1  SREG I bit.
- inst_done  in  1  CU pulse on the last cycle of each instruction (instruction boundary).
- reti_done  in  1  CU pulse when a RETI completes.
- pc_ret  in  PC_W  return address, valid on the inst_done cycle.
- stall_cu  out  1  holds the CU from SEL through JUMP.
- irq_ack  out  N_IRQ  one-hot, 1-cycle pulse; clears the taken source's flag.
- clr_i  out  1  1-cycle pulse; CU clears SREG I.
- stack_wr  out  1  1-cycle stack push strobe; the CU decrements SP.
- stack_data  out  8  byte to push.
- pc_load  out  1  1-cycle pulse; CU loads pc_vec into PC.
- pc_vec  out  PC_W  vector word address.
- irq_active  out  1  high from SEL through JUMP.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; hold_one=0; latched index and PC = 0.
  - All outputs 0. No pulse may be emitted on the reset cycle or the cycle after.
  - RST asserted mid-sequence aborts it immediately; partially pushed bytes are not completed.
- pending = irq_req & {N_IRQ{1}}. Winner = lowest set index (priority encoder).
- States: IDLE, SEL, PUSH_L, PUSH_H, JUMP. All outputs are registered.
- IDLE:
  - take = inst_done & i_flag & |irq_req & ~hold_one.
  - On take: latch the winner index and pc_ret → SEL.
  - Otherwise stay in IDLE.
- SEL (1 cycle):
  - stall_cu=1, irq_active=1, irq_ack[idx]=1, clr_i=1 → PUSH_L.
- PUSH_L (1 cycle):
  - stack_wr=1, stack_data=pc_lat[7:0] → PUSH_H.
- PUSH_H (1 cycle):
  - stack_wr=1, stack_data={{(16-PC_W){0}}, pc_lat[PC_W-1:8]} → JUMP.
- JUMP (1 cycle):
  - pc_load=1, pc_vec=VEC_BASE + 2*(idx+1), truncated to PC_W → IDLE.
- Latency and stall:
  - Entry takes exactly 4 cycles from the cycle after the take edge.
  - stall_cu is high for exactly those 4 cycles; irq_active mirrors stall_cu.
- hold_one:
  - Set by reti_done.
  - Cleared by the first inst_done seen while hold_one=1; that boundary is not eligible to take.
  - reti_done and inst_done in the same cycle: hold_one=1 and no take.
- Request changes:
  - Requests that rise or fall after the take edge do not change the latched index.
  - A source deasserting before SEL is still acked and vectored.
- New requests arriving during entry stay pending. They are evaluated at the next inst_done after JUMP, and only if i_flag has been set again (e.g. by RETI/SEI).
- inst_done and reti_done are ignored outside IDLE, except that reti_done still sets hold_one.
- i_flag=0: requests stay pending indefinitely and no output toggles.

Test Plan:
- Reset, then irq_req=0x0000004 (idx 2), i_flag=1, pc_ret=0x0123, inst_done pulse → next 4 cycles:
  - SEL: irq_ack=0x4, clr_i=1.
  - PUSH_L: stack_data=0x23.
  - PUSH_H: stack_data=0x01.
  - JUMP: pc_load=1, pc_vec=0x0006.
  - stall_cu is 1 across all 4 cycles.
- irq_req bits 0 and 17 set together → irq_ack=0x0000001, pc_vec=0x0002; bit 17 still pending afterwards and taken at the next eligible boundary with pc_vec=0x0024.
- i_flag=0 with irq_req=0x1, 10 inst_done pulses → no take, stall_cu stays 0; raising i_flag lets the next inst_done start SEL.
- reti_done with irq_req=0x2 pending and i_flag=1:
  - The first inst_done after reti_done does not take.
  - The second inst_done takes, giving pc_vec=0x0004.
  - Repeat with reti_done and inst_done in the same cycle: behaviour is identical.
- RST=1 during PUSH_H → next cycle: IDLE, all outputs 0, no pc_load. After release, a new take proceeds normally.
- pc_ret=0x3FFF with idx 24 → PUSH_L data 0xFF, PUSH_H data 0x3F, pc_vec=0x0032. Also check VEC_BASE=0x3800 variant: pc_vec=0x3832.
